// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FP status flags, classification mask encoding and class-mask width.
package fpnew_pkg;
    localparam int unsigned CLASS_MASK_BITS = 10;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [CLASS_MASK_BITS-1:0] {
        NEGINF     = 10'h001,
        NEGNORM    = 10'h002,
        NEGSUBNORM = 10'h004,
        NEGZERO    = 10'h008,
        POSZERO    = 10'h010,
        POSSUBNORM = 10'h020,
        POSNORM    = 10'h040,
        POSINF     = 10'h080,
        SNAN       = 10'h100,
        QNAN       = 10'h200
    } classmask_e;
endpackage

// File: rtl/fpnew_noncomp_wb_if.sv
// fpnew_noncomp_wb_if: unit-output and core-writeback handshakes of the non-comp writeback stage.
interface fpnew_noncomp_wb_if
    import fpnew_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Flen = 64,
    parameter type TagType = logic
);
    logic [Width-1:0] result;
    status_t status;
    logic extension_bit;
    classmask_e class_mask;
    logic is_class;
    TagType tag;
    logic in_valid;
    logic in_ready;
    logic [Flen-1:0] wb_result;
    status_t wb_status;
    TagType wb_tag;
    logic wb_valid;
    logic wb_ready;

    modport slave (
        input  result, status, extension_bit, class_mask, is_class, tag, in_valid, wb_ready,
        output in_ready, wb_result, wb_status, wb_tag, wb_valid
    );

    modport master (
        output result, status, extension_bit, class_mask, is_class, tag, in_valid, wb_ready,
        input  in_ready, wb_result, wb_status, wb_tag, wb_valid
    );
endinterface

// File: rtl/fpnew_wb_fifo.sv
// fpnew_wb_fifo: counter-based FIFO with explicit pointer wrap, so any Depth >= 1 works.
module fpnew_wb_fifo #(
    parameter int unsigned Depth = 2,
    parameter type EntryType = logic
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  EntryType data_in,
    output EntryType data_out,
    output logic     full,
    output logic     empty
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    EntryType mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign full = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
endmodule

// File: rtl/fpnew_noncomp_wb.sv
// fpnew_noncomp_wb: formats non-comp results to FLEN, queues them for writeback, keeps sticky fflags.
// Sticky flag register is built only when FPNEW_WB_STICKY_FLAGS_EN is defined.
module fpnew_noncomp_wb
    import fpnew_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Flen = 64,
    parameter int unsigned Depth = 2,
    parameter type TagType = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fpnew_noncomp_wb_if.slave    bus,
    input  logic                 flush_i,
    input  logic                 fflags_clr_i,
    output logic [4:0]           fflags_o,
    output logic                 busy_o
);
    typedef struct packed {
        logic [Flen-1:0] value;
        status_t status;
        TagType tag;
    } entry_t;

    if (Flen < Width || Flen < CLASS_MASK_BITS) begin : g_bad_flen
        $error("fpnew_noncomp_wb: Flen must cover Width and the class mask");
    end

    entry_t in_entry, head;
    logic full, empty, push, pop;

    // NaN-box (or sign-extend) the result; class masks are zero-extended instead.
    always_comb begin
        in_entry.value = {Flen{bus.extension_bit}};
        in_entry.value[Width-1:0] = bus.result;
        if (bus.is_class) begin
            in_entry.value = '0;
            in_entry.value[CLASS_MASK_BITS-1:0] = bus.class_mask;
        end
        in_entry.status = bus.status;
        in_entry.tag = bus.tag;
    end

    assign push = bus.in_valid & ~full & ~flush_i;
    assign pop = ~empty & bus.wb_ready & ~flush_i;

    fpnew_wb_fifo #(
        .Depth(Depth),
        .EntryType(entry_t)
    ) i_fifo (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .flush(flush_i),
        .push(push),
        .pop(pop),
        .data_in(in_entry),
        .data_out(head),
        .full(full),
        .empty(empty)
    );

    assign bus.in_ready = ~full;
    assign bus.wb_valid = ~empty;
    assign bus.wb_result = head.value;
    assign bus.wb_status = head.status;
    assign bus.wb_tag = head.tag;
    assign busy_o = ~empty;

`ifdef FPNEW_WB_STICKY_FLAGS_EN
    logic [4:0] fflags_q;

    // Clear takes effect before the same-cycle pop's flags are merged in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | (pop ? head.status : 5'b0);
    end

    assign fflags_o = fflags_q;
`else
    logic unused_fflags_clr;

    assign unused_fflags_clr = fflags_clr_i;
    assign fflags_o = '0;
`endif
endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// tb_fpnew_noncomp_wb: directed plus randomized checks of fpnew_noncomp_wb against a queue model.
module tb_fpnew_noncomp_wb;
    import fpnew_pkg::*;

    localparam int DEPTH = 2;
    typedef logic [3:0] tag_t;
    typedef struct {
        logic [63:0] v;
        logic [4:0] s;
        logic [3:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush = 1'b0;
    logic clr = 1'b0;
    logic [4:0] fflags;
    logic busy;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [4:0] ff = '0;

    fpnew_noncomp_wb_if #(.Width(32), .Flen(64), .TagType(tag_t)) bus ();

    fpnew_noncomp_wb #(
        .Width(32),
        .Flen(64),
        .Depth(DEPTH),
        .TagType(tag_t)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .bus(bus),
        .flush_i(flush),
        .fflags_clr_i(clr),
        .fflags_o(fflags),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fmt();
        logic [9:0] m;
        m = bus.class_mask;
        return bus.is_class ? {54'b0, m} : {{32{bus.extension_bit}}, bus.result};
    endfunction

    task automatic check_outputs();
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() != DEPTH));
        chk("wb_valid", 64'(bus.wb_valid), 64'(q.size() != 0));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("fflags", 64'(fflags), 64'(ff));
        if (q.size() != 0) begin
            chk("wb_result", bus.wb_result, q[0].v);
            chk("wb_status", 64'(bus.wb_status), 64'(q[0].s));
            chk("wb_tag", 64'(bus.wb_tag), 64'(q[0].t));
        end
    endtask

    task automatic step();
        int n;
        logic pu, po;
        logic [4:0] ps;
        exp_t e, h;
        n = q.size();
        pu = bus.in_valid && n != DEPTH && !flush;
        po = n != 0 && bus.wb_ready && !flush;
        e.v = fmt();
        e.s = bus.status;
        e.t = bus.tag;
        ps = '0;
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (po) begin
                h = q.pop_front();
                ps = h.s;
            end
            if (pu) q.push_back(e);
        end
`ifdef FPNEW_WB_STICKY_FLAGS_EN
        ff = (clr ? 5'b0 : ff) | ps;
`endif
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 64'(bus.wb_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_result"}, bus.wb_result, 64'd0);
        chk({tag, "_status"}, 64'(bus.wb_status), 64'd0);
        chk({tag, "_fflags"}, 64'(fflags), 64'd0);
    endtask

    initial begin
        bus.result = '0;
        bus.status = '0;
        bus.extension_bit = 1'b0;
        bus.class_mask = POSZERO;
        bus.is_class = 1'b0;
        bus.tag = '0;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        // SGNJ result NaN-boxed into FLEN=64
        bus.in_valid = 1'b1;
        bus.result = 32'h3F80_0000;
        bus.extension_bit = 1'b1;
        bus.tag = 4'd1;
        step();
        chk("sgnj_valid", 64'(bus.wb_valid), 64'd1);
        chk("sgnj_value", bus.wb_result, 64'hFFFF_FFFF_3F80_0000);
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        step();

        // classify, then a CMP result behind it
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.is_class = 1'b1;
        bus.class_mask = POSNORM;
        step();
        chk("class_value", bus.wb_result, 64'h40);
        bus.is_class = 1'b0;
        bus.extension_bit = 1'b0;
        bus.result = 32'd1;
        step();
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        step();
        chk("cmp_value", bus.wb_result, 64'h1);
        step();

        // backpressure: three back-to-back pushes into a 2-deep FIFO
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.tag = tag_t'(i);
            step();
        end
        chk("bp_full", 64'(bus.in_ready), 64'd0);
        bus.wb_ready = 1'b1;
        step();
        chk("bp_tag1", 64'(bus.wb_tag), 64'd1);
        step();
        chk("bp_tag2", 64'(bus.wb_tag), 64'd2);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drained", 64'(bus.wb_valid), 64'd0);

        // sticky flags: NV then NX, then clear together with a DZ pop
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.status = 5'b10000;
        step();
        bus.status = 5'b00001;
        step();
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        step();
        step();
`ifdef FPNEW_WB_STICKY_FLAGS_EN
        chk("sticky_acc", 64'(fflags), 64'b10001);
`else
        chk("sticky_off", 64'(fflags), 64'd0);
`endif
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.status = 5'b01000;
        step();
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
`ifdef FPNEW_WB_STICKY_FLAGS_EN
        chk("sticky_clr_pop", 64'(fflags), 64'b01000);
`else
        chk("sticky_clr_off", 64'(fflags), 64'd0);
`endif

        // flush with two entries queued and a push in the flush cycle
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.status = '0;
        for (int i = 0; i < 2; i++) begin
            bus.tag = tag_t'(4 + i);
            step();
        end
        bus.tag = 4'd9;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(bus.wb_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        step();
        chk("flush_no_push", 64'(busy), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = 1'($urandom_range(0, 3) != 0);
            bus.wb_ready = 1'($urandom_range(0, 2) != 0);
            bus.result = $urandom;
            bus.extension_bit = 1'($urandom);
            bus.is_class = 1'($urandom_range(0, 3) == 0);
            bus.class_mask = classmask_e'(10'(1 << $urandom_range(0, 9)));
            bus.status = bus.is_class ? 5'b0 : 5'($urandom);
            bus.tag = tag_t'($urandom);
            flush = 1'($urandom_range(0, 15) == 0);
            clr = 1'($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;
        clr = 1'b0;

        // asynchronous reset in the middle of a burst
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.result = 32'hDEAD_BEEF;
        bus.is_class = 1'b0;
        bus.status = 5'b00110;
        step();
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values("async_rst");
        q.delete();
        ff = '0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpnew_noncomp_wb.md
# fpnew_noncomp_wb

Writeback end of the non-computational FP unit's output handshake: accepts result, status, extension bit, class mask and tag, formats them into an FLEN-wide register-file value, buffers them in a small FIFO, and presents them to the core's writeback port. It owns the unit's `out_ready_i` and accumulates sticky IEEE exception flags (fflags) for the CSR file.

## Interface
- `Width`, default 32: operand/result width of the attached unit's format.
- `Flen`, default 64: register-file width; must be `>= Width` and `>= 10`.
- `Depth`, default 2: FIFO entries, `>= 1`; non-power-of-two values are legal.
- `TagType`, default `logic`: tag type, passed through unchanged.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `result_i`, in, `Width`: unit result.
- `status_i`, in, `fpnew_pkg::status_t`: flags {NV, DZ, OF, UF, NX}.
- `extension_bit_i`, in, 1: upper-bit fill value.
- `class_mask_i`, in, `fpnew_pkg::classmask_e` (10 bits): classification result.
- `is_class_i`, in, 1: the result is a class mask.
- `tag_i`, in, `TagType`: operation tag.
- `in_valid_i`, in, 1: unit output valid.
- `in_ready_o`, out, 1: connects to the unit's `out_ready_i`.
- `flush_i`, in, 1: synchronous flush.
- `wb_result_o`, out, `Flen`: formatted writeback value.
- `wb_status_o`, out, `status_t`: flags of the head entry.
- `wb_tag_o`, out, `TagType`: tag of the head entry.
- `wb_valid_o`, out, 1: head entry valid.
- `wb_ready_i`, in, 1: core accepts the head entry.
- `fflags_o`, out, 5: sticky accumulated flags.
- `fflags_clr_i`, in, 1: clear the sticky flags.
- `busy_o`, out, 1: FIFO non-empty.

## Operation
- **Formatting at enqueue:**
  - `is_class_i=1`: `{(Flen-10)'0, class_mask_i}`.
  - Otherwise: `{(Flen-Width){extension_bit_i}, result_i}`.
- **Entry contents:** formatted value, `status_i`, `tag_i`. Class-entry status is stored as given (zero from the unit).
- **Push:** `in_valid_i & in_ready_o & ~flush_i`.
- **Pop:** `wb_valid_o & wb_ready_i & ~flush_i`.
- **Occupancy:** counter `count` of width `$clog2(Depth+1)`. Read and write pointers wrap explicitly from `Depth-1` to 0.
- **Outputs:**
  - `in_ready_o = (count != Depth)`, a pure function of registered state, with no combinational path from `wb_ready_i`.
  - `wb_valid_o = (count != 0)`.
  - `wb_*` outputs show the entry at the read pointer.
  - `busy_o = wb_valid_o`.
- **Simultaneous push and pop:** legal whenever `in_ready_o=1`; `count` is unchanged and both pointers advance. When full, push is blocked even if a pop occurs in that cycle.
- **Flush:** pointers and `count` go to 0 at the next edge. Any push or pop in the flush cycle is discarded. Sticky flags are not affected.
- **Sticky flags:** on each pop, `fflags_q <= fflags_q | wb_status_o`. On `fflags_clr_i`, `fflags_q <= 0`. When a clear and a pop occur in the same cycle, the result is `fflags_q <= wb_status_o` (clear first, then the pop's flags are recorded).

## Timing
- **Reset values:** all pointers, `count`, `fflags_q` and storage are 0. Outputs after reset: `wb_valid_o=0`, `busy_o=0`, `in_ready_o=1`, `wb_result_o=0`, `wb_status_o=0`, `fflags_o=0`.
- **Latency:** 1 cycle. A push at edge N makes `wb_valid_o=1` after edge N; with `wb_ready_i=1` it pops at edge N+1.
- **Throughput:** 1 per cycle for `Depth>=2`. With `Depth=1`, one entry every 2 cycles, because a full FIFO does not accept a new entry in the same cycle it pops.
- **Reset mid-operation:** reset asserted at any time empties the FIFO immediately, independent of the clock; partially accepted data is lost.
- **Handshake hold:** `wb_*` outputs are held stable while `wb_valid_o=1 & ~wb_ready_i`.

## Configuration
- Macro `FPNEW_WB_STICKY_FLAGS_EN`.
  - Defined: the `fflags_q` register and its accumulation logic are built as described above.
  - Undefined: no flag register is built; `fflags_o` is tied to `'0` and `fflags_clr_i` is ignored. `wb_status_o` still carries per-entry flags.

## Structure
- `fpnew_pkg` provides `status_t` and `classmask_e`.
- `fpnew_pkg` gains constant `CLASS_MASK_BITS = 10`, used for class-mask formatting and the `Flen` width check.
- One sub-module, `fpnew_wb_fifo`: parameters `Depth` and entry type, ports push/pop/flush, full/empty. It holds the pointers and counter. The top module holds formatting and flag logic.

## Test plan
- **FP32 SGNJ into FLEN=64:** `result_i=32'h3F80_0000`, `extension_bit_i=1` → `wb_result_o=64'hFFFF_FFFF_3F80_0000`, `wb_valid_o` high one cycle after the push.
- **Classify:** `is_class_i=1`, `class_mask_i=10'h040` (POSNORM) → `wb_result_o=64'h40`. CMP with `extension_bit_i=0`, `result_i=1` → `64'h1`.
- **Backpressure, Depth=2:** hold `wb_ready_i=0` and push 3 back-to-back → `in_ready_o` low after 2 pushes. Release → tags pop in order 0, 1, 2 with no loss.
- **Sticky flags:** pop entries with NV=1, then NX=1 → `fflags_o=5'b10001`. Assert `fflags_clr_i` together with a pop carrying DZ → `fflags_o=5'b01000`.
- **Flush:** with 2 entries queued, assert `flush_i` together with a push → next cycle `wb_valid_o=0`, `busy_o=0`, `in_ready_o=1`, and the flushed-cycle push does not appear.
- **Async reset mid-burst:** assert `rst_ni=0` between edges → outputs immediately reach reset values. With the macro undefined, `fflags_o=0` throughout.
